// File: rtl/edge_cache_ctrl_pkg.sv
// rtl/edge_cache_ctrl_pkg.sv - shared types for the edge cache controller
// Purpose: FSM state type built on the encodings in constants.v.
// Ports: none (package).
`include "constants.v"

package edge_cache_ctrl_pkg;

  typedef enum logic {
    IDLE  = `EDGE_CACHE_ST_IDLE,
    CLEAR = `EDGE_CACHE_ST_CLEAR
  } state_t;

endpackage

// File: rtl/edge_cache_ctrl_if.sv
// rtl/edge_cache_ctrl_if.sv - request/response bundle of the edge cache controller
// Purpose: groups clear control, fill handshake, read port and occupancy count.
// Ports: master = requester (drives clear_start, fill_*, read_en/to/from);
//        slave  = edge_cache_ctrl (drives busy, fill_ready, read_valid/hit/data, valid_count).
`include "constants.v"

interface edge_cache_ctrl_if #(
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
);
  logic                     clear_start;
  logic                     busy;
  logic                     fill_valid;
  logic                     fill_ready;
  logic [INDEX_WIDTH-1:0]   fill_to;
  logic [INDEX_WIDTH-1:0]   fill_from;
  logic [VALUE_WIDTH-1:0]   fill_data;
  logic                     read_en;
  logic [INDEX_WIDTH-1:0]   read_to;
  logic [INDEX_WIDTH-1:0]   read_from;
  logic                     read_valid;
  logic                     read_hit;
  logic [VALUE_WIDTH-1:0]   read_data;
  logic [2*INDEX_WIDTH:0]   valid_count;

  modport master (
    output clear_start, fill_valid, fill_to, fill_from, fill_data, read_en, read_to, read_from,
    input  busy, fill_ready, read_valid, read_hit, read_data, valid_count
  );

  modport slave (
    input  clear_start, fill_valid, fill_to, fill_from, fill_data, read_en, read_to, read_from,
    output busy, fill_ready, read_valid, read_hit, read_data, valid_count
  );
endinterface

// File: rtl/constants.v
// rtl/constants.v - shared parameter defaults and FSM state encodings for edge_cache_ctrl
`ifndef EDGE_CACHE_CONSTANTS_V
`define EDGE_CACHE_CONSTANTS_V

`define DEFAULT_MAX_NODES   32
`define DEFAULT_INDEX_WIDTH 5
`define DEFAULT_VALUE_WIDTH 16

`define EDGE_CACHE_ST_IDLE  1'b0
`define EDGE_CACHE_ST_CLEAR 1'b1

`endif

// File: rtl/edge_cache_ctrl_bank.sv
// rtl/edge_cache_ctrl_bank.sv - edge weight storage (module edge_cache_bank)
// Purpose: single-clock RAM, synchronous write, registered read, no reset on contents.
// Ports: clock; we/waddr/wdata write port; raddr read address; rdata registered read data.
module edge_cache_bank #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read samples the old word on a same-address write (read-before-write).
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/edge_cache_ctrl.sv
// rtl/edge_cache_ctrl.sv - edge weight cache with valid bits, occupancy count and clear sweep
// Purpose: caches edge weights addressed {to, from}; one valid bit per entry; a clear
//          sweep invalidates one row per cycle. Optional macro EDGE_CACHE_FWD_EN adds
//          same-cycle fill-to-read forwarding.
// Ports: clock, reset (sync, active-high); bus (edge_cache_ctrl_if.slave).
`include "constants.v"

module edge_cache_ctrl
  import edge_cache_ctrl_pkg::*;
#(
  parameter int                     MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int                     INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int                     VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter logic [VALUE_WIDTH-1:0] MISS_VALUE  = '1
) (
  input  logic clock,
  input  logic reset,
  edge_cache_ctrl_if.slave bus
);
  localparam int CW = 2*INDEX_WIDTH+1;
  localparam logic [INDEX_WIDTH-1:0] ROW_LAST = INDEX_WIDTH'(MAX_NODES-1);

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   row_q;
  logic [MAX_NODES-1:0]     valid_q [MAX_NODES];
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            clear_cnt;
  logic                     read_valid_q, hit_q, fwd_q;
  logic [VALUE_WIDTH-1:0]   fwd_data_q, bank_q;
  logic                     fill_acc, fill_in_range, fill_wr, fill_new;
  logic                     read_in_range, read_hit_d, fwd_d;

  assign fill_acc      = bus.fill_valid && bus.fill_ready;
  assign fill_in_range = (int'(bus.fill_to) < MAX_NODES) && (int'(bus.fill_from) < MAX_NODES);
  // Out-of-range beats are accepted but discarded.
  assign fill_wr       = fill_acc && fill_in_range;
  assign fill_new      = fill_wr && !valid_q[bus.fill_to][bus.fill_from];
  assign read_in_range = (int'(bus.read_to) < MAX_NODES) && (int'(bus.read_from) < MAX_NODES);
  assign read_hit_d    = read_in_range && valid_q[bus.read_to][bus.read_from];
  assign clear_cnt     = (state_q == CLEAR) ? CW'($countones(valid_q[row_q])) : '0;

`ifdef EDGE_CACHE_FWD_EN
  assign fwd_d = fill_wr && bus.read_en && (bus.fill_to == bus.read_to) &&
                 (bus.fill_from == bus.read_from);
`else
  assign fwd_d = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; clear_start is ignored while sweeping
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear_start) state_d = CLEAR;
      CLEAR:   if (row_q == ROW_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy       = (state_q == CLEAR);
    bus.fill_ready = (state_q == IDLE);
  end

  // Valid bits, occupancy counter, sweep row and read response flags
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q        <= '0;
      valid_q      <= '{default: '0};
      count_q      <= '0;
      read_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      fwd_q        <= 1'b0;
    end else begin
      // Row index is held at 0 outside the sweep so a back-to-back clear restarts at row 0.
      row_q <= (state_q == CLEAR && row_q != ROW_LAST) ? row_q + 1'b1 : '0;
      if (state_q == CLEAR) valid_q[row_q] <= '0;
      if (fill_wr) valid_q[bus.fill_to][bus.fill_from] <= 1'b1;
      // fill_ready is low during the sweep, so increment and decrement never overlap.
      count_q      <= count_q + CW'(fill_new) - clear_cnt;
      read_valid_q <= bus.read_en;
      hit_q        <= bus.read_en && read_hit_d;
      fwd_q        <= fwd_d;
    end
  end

  always_ff @(posedge clock) begin
    fwd_data_q <= bus.fill_data;
  end

  edge_cache_bank #(
    .ADDR_WIDTH(2*INDEX_WIDTH),
    .DATA_WIDTH(VALUE_WIDTH)
  ) u_bank (
    .clock(clock),
    .we   (fill_wr),
    .waddr({bus.fill_to, bus.fill_from}),
    .wdata(bus.fill_data),
    .raddr({bus.read_to, bus.read_from}),
    .rdata(bank_q)
  );

  assign bus.read_valid  = read_valid_q;
  assign bus.read_hit    = hit_q || fwd_q;
  assign bus.read_data   = fwd_q ? fwd_data_q : (hit_q ? bank_q : MISS_VALUE);
  assign bus.valid_count = count_q;
endmodule

// File: doc/edge_cache_ctrl.md
EDGE_CACHE_CTRL -- requirements
Module: edge_cache_ctrl

Interface
REQ-001 SHALL have parameter MAX_NODES, default `DEFAULT_MAX_NODES, meaning the node count per side of the edge matrix.
REQ-002 SHALL have parameter INDEX_WIDTH, default `DEFAULT_INDEX_WIDTH, meaning the node index width.
REQ-003 SHALL have parameter VALUE_WIDTH, default `DEFAULT_VALUE_WIDTH, meaning the edge weight width.
REQ-004 SHALL have parameter MISS_VALUE, default all-ones of VALUE_WIDTH, meaning the weight returned on a miss ("no edge / infinity").
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL provide ports as follows:
- clock  in  1  -- the single clock; all logic on its rising edge.
- reset  in  1  -- synchronous, active-high reset.
- clear_start  in  1  -- pulse that starts invalidation of all entries.
- busy  out  1  -- clear sweep in progress.
- fill_valid  in  1  -- fill beat present.
- fill_ready  out  1  -- fill beat can be accepted.
- fill_to  in  INDEX_WIDTH  -- destination node of the fill.
- fill_from  in  INDEX_WIDTH  -- source node of the fill.
- fill_data  in  VALUE_WIDTH  -- edge weight to store.
- read_en  in  1  -- read request.
- read_to  in  INDEX_WIDTH  -- destination node of the read.
- read_from  in  INDEX_WIDTH  -- source node of the read.
- read_valid  out  1  -- read response present.
- read_hit  out  1  -- response entry was valid.
- read_data  out  VALUE_WIDTH  -- response weight.
- valid_count  out  2*INDEX_WIDTH+1  -- number of valid entries.

Function
REQ-007 SHALL form the entry address as {to, from}, with to in the upper INDEX_WIDTH bits, for both fill and read.
REQ-008 SHALL keep one valid bit per entry (MAX_NODES**2 bits) beside the weight memory.
REQ-009 SHALL accept a fill beat when fill_valid && fill_ready; that beat writes the weight and sets the valid bit.
REQ-010 SHALL drive fill_ready = (state == IDLE), not gated by clear_start.
REQ-011 SHALL increment valid_count on an accepted fill only when the entry was previously invalid; a rewrite of a valid entry leaves valid_count unchanged.
REQ-012 SHALL silently drop a fill with fill_to or fill_from >= MAX_NODES: beat accepted, no write, no count change.
REQ-013 SHALL have fixed 1-cycle read latency: read_valid equals read_en delayed one cycle, and reads are accepted in every state.
REQ-014 SHALL return read_hit=1 with the stored weight when the entry is valid; otherwise read_hit=0 and read_data=MISS_VALUE.
REQ-015 SHALL treat a read with an out-of-range index as a miss.
REQ-016 SHALL implement the FSM states IDLE and CLEAR:
- IDLE -> CLEAR on clear_start.
- CLEAR invalidates row r (all from for to=r) on sweep cycle r, r = 0..MAX_NODES-1.
- CLEAR -> IDLE after row MAX_NODES-1.
REQ-017 SHALL assert busy exactly while in CLEAR; a clear therefore lasts MAX_NODES cycles.
REQ-018 SHALL decrement valid_count per cleared entry, reaching 0 on the cycle busy falls.
REQ-019 SHALL ignore clear_start while in CLEAR.
REQ-020 SHALL process a fill accepted on the same cycle as clear_start normally; the subsequent sweep then invalidates it.
REQ-021 SHALL give reads during CLEAR the valid state as of the cycle the read was issued.
REQ-022 SHALL, for a read and an accepted fill to the same address on the same cycle, return the pre-write content (read-before-write) unless REQ-027 applies.

Reset
REQ-023 SHALL, on reset, clear all valid bits, set valid_count=0, state=IDLE, busy=0, read_valid=0, read_hit=0, read_data=MISS_VALUE, and leave fill_ready=1 the following cycle.
REQ-024 SHALL not initialise the weight memory.
REQ-025 SHALL let reset during CLEAR abort the sweep and take effect on the next edge.

Configuration
REQ-026 SHALL compile write-to-read forwarding in only when macro EDGE_CACHE_FWD_EN is defined.
REQ-027 SHALL, with EDGE_CACHE_FWD_EN defined, answer a same-cycle same-address read and accepted in-range fill with fill_data and read_hit=1; without it, REQ-022 holds.

Structure
REQ-028 SHALL take DEFAULT_MAX_NODES, DEFAULT_INDEX_WIDTH, DEFAULT_VALUE_WIDTH and FSM state encodings from constants.v.
REQ-029 SHALL place the weight storage in a sub-module edge_cache_bank: single clock, synchronous write, registered read, block-RAM inferable.
REQ-030 SHALL keep valid bits, counter and FSM in edge_cache_ctrl.

Verification (MAX_NODES=32, INDEX_WIDTH=5, VALUE_WIDTH=16)
REQ-031 SHALL cover: after reset, read (to=3, from=4) -> next cycle read_valid=1, read_hit=0, read_data=16'hFFFF, valid_count=0.
REQ-032 SHALL cover: fill (3,4)=16'd17, then read (3,4) -> read_hit=1, read_data=17; fill (3,4)=9 again -> valid_count stays 1, read returns 9.
REQ-033 SHALL cover: fill 5 distinct entries, pulse clear_start -> busy high exactly 32 cycles, fill_ready=0 throughout, valid_count=0 at end, all reads miss.
REQ-034 SHALL cover: fill with fill_to=5'd31 (legal) and with MAX_NODES=20 and fill_to=25 -> first stored, second dropped with valid_count unchanged.
REQ-035 SHALL cover: same-cycle fill (7,7)=42 and read (7,7) on an empty entry -> miss without EDGE_CACHE_FWD_EN; hit with 42 when it is defined.
REQ-036 SHALL cover: reset asserted on sweep cycle 10 -> busy=0, state IDLE, valid_count=0 the next cycle.
